// File: rtl/io_port_pkg.sv
// Shared types and default parameter values for the IO port bank.
package io_port_pkg;

    localparam int unsigned DEFAULT_DATA_W      = 32;
    localparam int unsigned DEFAULT_N_IN        = 2;
    localparam int unsigned DEFAULT_N_OUT       = 2;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_KEEP_OLDEST = 0;

    // Input channel occupancy.
    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFull    = 2'd1,
        StOverrun = 2'd2
    } ch_state_e;

endpackage

// File: rtl/io_in_channel.sv
// One input-port channel: strobe synchroniser, rising-edge capture, occupancy FSM and
// holding register.
module io_in_channel
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter bit          KEEP_OLDEST = 1'b0
) (
    input  logic              clock,
    input  logic              clr,
    input  logic [DATA_W-1:0] data_i,
    input  logic              strobe_i,
    input  logic              rd_hit_i,
    output logic [DATA_W-1:0] hold_o,
    output logic              ready_o,
    output logic              ovf_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // Marks synchroniser stages that hold a real sample rather than a reset value.
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    // Set once the synchronised strobe has been observed low; a capture needs it.
    logic                   armed_q, armed_d;
    logic                   capture;
    ch_state_e              state_q, state_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   ovf_q, ovf_d;

    logic sync_level;
    logic sync_valid;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign sync_valid = vld_q[SYNC_STAGES-1];

    // Synchroniser shift, arming and capture detection.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], strobe_i};
        vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
        capture = sync_level & armed_q;
        armed_d = armed_q;
        if (sync_valid && !sync_level) begin
            armed_d = 1'b1;
        end else if (capture) begin
            armed_d = 1'b0;
        end
    end

    // Occupancy FSM next state and holding register load policy.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        case (state_q)
            StEmpty: begin
                if (capture) begin
                    state_d = StFull;
                    hold_d  = data_i;
                end
            end
            StFull, StOverrun: begin
                if (capture && rd_hit_i) begin
                    // Reader takes the old word; the new one always lands.
                    state_d = StFull;
                    hold_d  = data_i;
                end else if (capture) begin
                    state_d = StOverrun;
                    ovf_d   = 1'b1;
                    if (!KEEP_OLDEST) begin
                        hold_d = data_i;
                    end
                end else if (rd_hit_i) begin
                    state_d = StEmpty;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            sync_q  <= '0;
            vld_q   <= '0;
            armed_q <= 1'b0;
            state_q <= StEmpty;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    assign hold_o  = hold_q;
    assign ready_o = (state_q != StEmpty);
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/io_port_bank.sv
// Bank of strobed input ports and acknowledged output ports sharing one datapath bus.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned N_IN        = DEFAULT_N_IN,
    parameter int unsigned N_OUT       = DEFAULT_N_OUT,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned KEEP_OLDEST = DEFAULT_KEEP_OLDEST,
    parameter int unsigned IN_SEL_W    = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int unsigned OUT_SEL_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clock,
    input  logic                    clr,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         strobe_in,
    input  logic                    rd_en,
    input  logic [IN_SEL_W-1:0]     rd_sel,
    output logic [DATA_W-1:0]       bus_out,
    output logic [N_IN-1:0]         in_ready,
    output logic [N_IN-1:0]         in_ovf,
    input  logic                    wr_en,
    input  logic [OUT_SEL_W-1:0]    wr_sel,
    input  logic [DATA_W-1:0]       bus_in,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ack
);

    logic [DATA_W-1:0] hold_w [N_IN];
    logic [N_IN-1:0]   rd_hit;

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign rd_hit[i] = rd_en && (rd_sel == IN_SEL_W'(i));

        io_in_channel #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES),
            .KEEP_OLDEST (KEEP_OLDEST != 0)
        ) u_ch (
            .clock    (clock),
            .clr      (clr),
            .data_i   (in_data[i*DATA_W +: DATA_W]),
            .strobe_i (strobe_in[i]),
            .rd_hit_i (rd_hit[i]),
            .hold_o   (hold_w[i]),
            .ready_o  (in_ready[i]),
            .ovf_o    (in_ovf[i])
        );
    end

    // Read mux; out-of-range selects match no channel and so drive zero.
    always_comb begin
        bus_out = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (rd_hit[i]) begin
                bus_out = hold_w[i];
            end
        end
    end

    logic [DATA_W-1:0] out_data_q [N_OUT];
    logic [DATA_W-1:0] out_data_d [N_OUT];
    logic [N_OUT-1:0]  out_valid_q, out_valid_d;

    // Output channel update: a write beats a coincident acknowledge.
    always_comb begin
        out_valid_d = out_valid_q;
        for (int j = 0; j < N_OUT; j++) begin
            out_data_d[j] = out_data_q[j];
            if (wr_en && (wr_sel == OUT_SEL_W'(j))) begin
                out_data_d[j]  = bus_in;
                out_valid_d[j] = 1'b1;
            end else if (out_ack[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
    end

    // Output channel registers.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            out_valid_q <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                out_data_q[j] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int j = 0; j < N_OUT; j++) begin
                out_data_q[j] <= out_data_d[j];
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_data[j*DATA_W +: DATA_W] = out_data_q[j];
    end

    assign out_valid = out_valid_q;

endmodule
